mem_port_arbiter: RTL and testbench

- Shares one backing memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the five-stage pipelined RISC-V core.
- Sequences each access as a req/ack transaction and returns read data to the correct requester.
- Drives a stall to the pipeline so that PC, IFID, IDEX, EXMEM and MEMWB hold while an access is outstanding.
- Replaces the separate instruction and data memory ports when the core is built against a unified memory.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arb_starve_ctr.sv | 18 +
 rtl/mem_port_arbiter.sv | 92 +++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester ids and default widths for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D, RESP} state_t;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D = 1'b1;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of data grants issued while fetch waits; at_limit forces a fetch grant
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_grant,
  input  logic if_grant,
  output logic at_limit
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || if_grant || !if_req) cnt <= '0;
    else if (d_grant && !at_limit) cnt <= cnt + 1'b1;
  assign at_limit = cnt == CW'(STARVE_LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters (data first; MEM_PORT_ARBITER_STARVE_GUARD_EN bounds fetch starvation)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);
  state_t state;
  logic force_if, gnt, grant_now;
  assign gnt = d_req_i && !force_if ? REQ_D : REQ_IF;
  assign grant_now = state == IDLE && (d_req_i || if_req_i);
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
  logic at_limit;
  mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk(clk_i),
    .rst(rst_i),
    .if_req(if_req_i),
    .d_grant(grant_now && gnt == REQ_D),
    .if_grant(grant_now && gnt == REQ_IF),
    .at_limit(at_limit)
  );
  assign force_if = at_limit && if_req_i && d_req_i;
`else
  assign force_if = 1'b0;
`endif
  assign stall_o = !rst_i && ((if_req_i && !if_ack_o) || (d_req_i && !d_ack_o));
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      if_rdata_o <= '0;
      d_rdata_o <= '0;
      if_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o <= 1'b0;
      case (state)
        IDLE:
          if (grant_now) begin
            state <= gnt == REQ_D ? GRANT_D : GRANT_IF;
            mem_req_o <= 1'b1;
            mem_we_o <= gnt == REQ_D && d_we_i;
            mem_addr_o <= gnt == REQ_D ? d_addr_i : if_addr_i;
            mem_wdata_o <= gnt == REQ_D ? d_wdata_i : '0;
          end
        GRANT_IF:
          if (mem_ack_i) begin
            state <= RESP;
            mem_req_o <= 1'b0;
            if (if_req_i) begin
              if_rdata_o <= mem_rdata_i;
              if_ack_o <= 1'b1;
            end
          end
        GRANT_D:
          if (mem_ack_i) begin
            state <= RESP;
            mem_req_o <= 1'b0;
            if (d_req_i) begin
              if (!mem_we_o) d_rdata_o <= mem_rdata_i;
              d_ack_o <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic if_req_i = 1'b0, if_ack_o, d_req_i = 1'b0, d_we_i = 1'b0, d_ack_o, stall_o;
  logic mem_req_o, mem_we_o, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, if_rdata_o, d_addr_i = '0, d_wdata_i = '0, d_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  int checks = 0, errors = 0;
  logic gw [5];
  int n;
  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    if_req_i = 1'b1;
    d_req_i = 1'b1;
    step();
    step();
    chk("rst_stall", stall_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_acks", {if_ack_o, d_ack_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0);
    chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
    if_req_i = 1'b0;
    d_req_i = 1'b0;
    rst_i = 1'b0;
    step();
    chk("idle_no_req", mem_req_o, 0);
    // fetch only
    if_req_i = 1'b1;
    if_addr_i = 32'h10;
    #1;
    chk("f_stall_req", stall_o, 1);
    step();
    chk("f_mem_req", mem_req_o, 1);
    chk("f_mem_addr", mem_addr_o, 32'h10);
    chk("f_mem_we", mem_we_o, 0);
    chk("f_stall_grant", stall_o, 1);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h93;
    step();
    chk("f_if_ack", if_ack_o, 1);
    chk("f_if_rdata", if_rdata_o, 32'h93);
    chk("f_mem_req_drop", mem_req_o, 0);
    chk("f_stall_ack", stall_o, 0);
    mem_ack_i = 1'b0;
    if_req_i = 1'b0;
    step();
    chk("f_ack_pulse", if_ack_o, 0);
    // simultaneous fetch and store
    if_req_i = 1'b1;
    if_addr_i = 32'h20;
    d_req_i = 1'b1;
    d_we_i = 1'b1;
    d_addr_i = 32'h100;
    d_wdata_i = 32'hDEADBEEF;
    step();
    chk("s_mem_we", mem_we_o, 1);
    chk("s_mem_addr", mem_addr_o, 32'h100);
    chk("s_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    step();
    chk("s_d_ack", d_ack_o, 1);
    chk("s_if_ack", if_ack_o, 0);
    chk("s_store_rdata", d_rdata_o, 0);
    chk("s_stall_if_wait", stall_o, 1);
    mem_ack_i = 1'b0;
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    step();
    chk("s_resp_no_grant", mem_req_o, 0);
    step();
    chk("s_if_grant", mem_req_o, 1);
    chk("s_if_addr", mem_addr_o, 32'h20);
    chk("s_if_we", mem_we_o, 0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h13;
    step();
    chk("s_if_ack2", if_ack_o, 1);
    chk("s_if_rdata", if_rdata_o, 32'h13);
    mem_ack_i = 1'b0;
    if_req_i = 1'b0;
    step();
    step();
    // load with delayed ack, address changes must be ignored
    d_req_i = 1'b1;
    d_addr_i = 32'h200;
    step();
    for (int i = 0; i < 6; i++) begin
      d_addr_i = 32'h999 + i;
      chk("l_mem_req", mem_req_o, 1);
      chk("l_mem_addr", mem_addr_o, 32'h200);
      chk("l_mem_we", mem_we_o, 0);
      chk("l_stall", stall_o, 1);
      chk("l_no_ack", d_ack_o, 0);
      if (i < 5) step();
    end
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hCAFEF00D;
    step();
    chk("l_d_ack", d_ack_o, 1);
    chk("l_d_rdata", d_rdata_o, 32'hCAFEF00D);
    mem_ack_i = 1'b0;
    d_req_i = 1'b0;
    step();
    step();
    // reset in the second cycle of a data grant
    d_req_i = 1'b1;
    d_addr_i = 32'h300;
    step();
    step();
    chk("r_mem_req_pre", mem_req_o, 1);
    rst_i = 1'b1;
    step();
    chk("r_mem_req", mem_req_o, 0);
    chk("r_no_ack", d_ack_o, 0);
    rst_i = 1'b0;
    d_req_i = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = 32'h40;
    step();
    chk("r_fetch_grant", mem_req_o, 1);
    chk("r_fetch_addr", mem_addr_o, 32'h40);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h55;
    step();
    chk("r_fetch_ack", if_ack_o, 1);
    chk("r_fetch_rdata", if_rdata_o, 32'h55);
    mem_ack_i = 1'b0;
    if_req_i = 1'b0;
    step();
    step();
    // data request withdrawn mid-grant
    d_req_i = 1'b1;
    d_addr_i = 32'h400;
    step();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h11111111;
    step();
    chk("w_load_rdata", d_rdata_o, 32'h11111111);
    mem_ack_i = 1'b0;
    d_req_i = 1'b0;
    step();
    step();
    d_req_i = 1'b1;
    d_addr_i = 32'h500;
    step();
    d_req_i = 1'b0;
    step();
    chk("w_mem_req_held", mem_req_o, 1);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'h22222222;
    step();
    chk("w_no_ack", d_ack_o, 0);
    chk("w_rdata_kept", d_rdata_o, 32'h11111111);
    chk("w_mem_req_drop", mem_req_o, 0);
    mem_ack_i = 1'b0;
    step();
    step();
    // both requesters held high, memory always acking
    d_req_i = 1'b1;
    d_we_i = 1'b1;
    d_addr_i = 32'h600;
    if_req_i = 1'b1;
    if_addr_i = 32'h60;
    mem_ack_i = 1'b1;
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      step();
      if (mem_req_o) begin
        gw[n] = mem_we_o;
        n++;
      end
    end
    chk("g_grant_count", n, 5);
    for (int k = 0; k < 4; k++) chk("g_data_grant", gw[k], 1);
`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    chk("g_fifth_grant", gw[4], 0);
`else
    chk("g_fifth_grant", gw[4], 1);
`endif
    mem_ack_i = 1'b0;
    d_req_i = 1'b0;
    if_req_i = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
